zz_block_builder: RTL
=====================

Name: zz_block_builder

Overview:
- Sits between the Huffman/entropy decoder and deQuant.
- Accepts a stream of run-length coefficient tokens in zigzag order.
- Expands zero runs, de-zigzags the coefficients into a natural-order 8x8 block, and presents the finished block with its channel to deQuant.
- Uses a ready/valid handshake upstream and downstream, with one assembly buffer plus one output register.

Parameters:
- COEF_W, 12, signed coefficient width; must match deQuant blockIn.
- CH_W, $clog2(`CH+1), channel index width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  token valid from entropy decoder.
- in_ready  out  1  builder can accept a token.
- in_coef  in  COEF_W  signed coefficient value (ignored when in_eob).
- in_run  in  4  number of zero coefficients preceding in_coef (ignored when in_eob).
- in_eob  in  1  end-of-block: all remaining positions are zero.
- in_ch  in  CH_W  channel (y, cb, cr) of the block; sampled on the block's first token.
- blockOut  out  [7:0][7:0] x COEF_W  signed natural-order block, [row][col].
- valid_out  out  1  blockOut/chOut valid.
- out_ready  in  1  downstream consumes the block.
- chOut  out  CH_W  channel of blockOut.
- err  out  1  one-cycle pulse on a run-overrun protocol error.

Behaviour:
- Reset (reset_n low, asynchronous):
  - valid_out=0, blockOut all 0, chOut=0, err=0.
  - Assembly buffer all 0, pos=0, started=0, state=FILL.
  - Any partial block is discarded.
- Accept: a token is taken on a rising edge with in_valid && in_ready. in_ready = (state==FILL), no combinational path from in_valid.
- Zigzag map, natural [r][c] -> index k (standard JPEG):
  - row0: 0 1 5 6 14 15 27 28
  - row1: 2 4 7 13 16 26 29 42
  - row2: 3 8 12 17 25 30 41 43
  - row3: 9 11 18 24 31 40 44 53
  - row4: 10 19 23 32 39 45 52 54
  - row5: 20 22 33 38 46 51 55 60
  - row6: 21 34 37 47 50 56 59 61
  - row7: 35 36 48 49 57 58 62 63
- Non-EOB token with t = pos+in_run <= 63:
  - Write in_coef at zigzag index t; skipped positions stay 0 because the buffer is pre-cleared.
  - pos <= t+1.
  - ZRL (run 15, coef 0) needs no special case.
- Channel capture: the first accepted token of a block (started==0, EOB included) latches in_ch and sets started.
- Block completes when:
  - an EOB is accepted; or
  - a non-EOB token makes t==63; or
  - an overrun occurs: t>63. In that case the coefficient is dropped, err pulses high for one cycle, and the block completes as for EOB.
- Transfer, only when the output register is free (!valid_out || out_ready):
  - blockOut <= completed buffer, including the final coefficient written that same cycle.
  - chOut <= latched channel; valid_out <= 1.
  - Assembly buffer cleared; pos=0; started=0.
- State FILL:
  - Completion with the output free: transfer on the same edge; valid_out visible the cycle after the completing token. Stay in FILL.
  - Completion with the output busy: go to HOLD, buffer kept intact.
- State HOLD:
  - in_ready=0.
  - When !valid_out || out_ready: transfer, then go to FILL.
- Output handshake:
  - valid_out && out_ready with no transfer that edge: valid_out <= 0; blockOut and chOut hold their last value.
  - valid_out && out_ready with a simultaneous transfer: valid_out stays 1 and new data replaces the old. Back-to-back blocks are sustained with no bubble.
  - blockOut and chOut are stable while valid_out && !out_ready.
- Throughput: 1 token per cycle in FILL; a block needs at least 1 token (EOB only) and at most 64.

Test Plan:
- DC only, output free: (run0, -5, ch=0) then EOB.
  - blockOut[0][0]=-5, all others 0, chOut=0.
  - valid_out rises the cycle after the EOB is accepted.
- Full order: 64 tokens (run0, coef=k), k=0..63, ch=1, no EOB.
  - blockOut[0][1]=1, [1][0]=2, [2][0]=3, [3][2]=18, [7][7]=63.
  - Completes on the 64th token; in_ready stays 1 throughout.
- Runs/ZRL: (run0, 10), (run15, 0), (run2, 7), EOB, ch=2.
  - blockOut[0][0]=10, [4][1]=7 (index 19), all others 0, chOut=2.
- Backpressure: out_ready=0; send block A (DC 1), then block B (DC 2).
  - A is held; in_ready drops after B's EOB.
  - Raise out_ready for one cycle: the next cycle shows B (blockOut[0][0]=2), valid_out stays 1, in_ready returns to 1.
- Overrun: tokens reaching pos=60, then (run5, 9).
  - err is high for exactly one cycle; the block is emitted with indices 60..63 zero; the next block starts at pos 0.
- Reset mid-block: 3 tokens accepted, then reset_n low asynchronously between edges.
  - valid_out=0 and blockOut=0 immediately.
  - After release, (run0, 4), EOB gives blockOut[0][0]=4, all others 0, with no residue from the aborted block.

Source files
------------

// File: rtl/zz_block_builder_if.sv
// Token and block handshake bundle between the entropy decoder, the block
// builder and deQuant. The master side produces tokens and consumes blocks.
interface zz_block_builder_if #(
  parameter int unsigned COEF_W = 12,
  parameter int unsigned CH_W   = 2
);
  // Upstream token stream (zigzag order, run-length coded)
  logic                             in_valid;
  logic                             in_ready;
  logic [COEF_W-1:0]                in_coef;
  logic [3:0]                       in_run;
  logic                             in_eob;
  logic [CH_W-1:0]                  in_ch;

  // Downstream finished block, natural order [row][col]
  logic [7:0][7:0][COEF_W-1:0]      blockOut;
  logic                             valid_out;
  logic                             out_ready;
  logic [CH_W-1:0]                  chOut;

  modport master (
    output in_valid, in_coef, in_run, in_eob, in_ch, out_ready,
    input  in_ready, blockOut, valid_out, chOut
  );

  modport slave (
    input  in_valid, in_coef, in_run, in_eob, in_ch, out_ready,
    output in_ready, blockOut, valid_out, chOut
  );
endinterface

// File: rtl/zz_block_builder.sv
// Expands run-length zigzag coefficient tokens into a natural-order 8x8 block
// and hands it to deQuant. One assembly buffer plus one output register; a
// completed block waits in the assembly buffer (HOLD) while the output is busy.
module zz_block_builder #(
  parameter int unsigned COEF_W = 12,
  parameter int unsigned CH_W   = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  zz_block_builder_if.slave bus,
  output logic            err
);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  // Zigzag index k -> natural flat index (row*8 + col)
  localparam logic [0:63][5:0] ZzNat = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  state_e                   state_q;
  logic [5:0]               pos_q;
  logic                     started_q;
  logic [CH_W-1:0]          ch_q;
  logic [63:0][COEF_W-1:0]  buf_q;
  logic [63:0][COEF_W-1:0]  block_q;
  logic                     valid_q;
  logic [CH_W-1:0]          ch_out_q;
  logic                     err_q;

  logic                     accept;
  logic [6:0]               t;
  logic                     write;
  logic                     overrun;
  logic                     complete;
  logic                     out_free;
  logic [CH_W-1:0]          ch_cur;
  logic [63:0][COEF_W-1:0]  buf_wr;

  assign accept   = bus.in_valid && (state_q == StFill);
  assign t        = {1'b0, pos_q} + {3'b000, bus.in_run};
  assign write    = accept && !bus.in_eob && (t <= 7'd63);
  assign overrun  = accept && !bus.in_eob && (t > 7'd63);
  assign complete = accept && (bus.in_eob || (t >= 7'd63));
  assign out_free = !valid_q || bus.out_ready;
  // Channel is taken from the first token of the block, EOB included
  assign ch_cur   = started_q ? ch_q : bus.in_ch;

  // Assembly buffer including the coefficient being accepted this cycle
  always_comb begin
    buf_wr = buf_q;
    if (write) buf_wr[ZzNat[t[5:0]]] = bus.in_coef;
  end

  // Fill/hold state machine with registered output block, channel, valid and err
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFill;
      pos_q     <= '0;
      started_q <= 1'b0;
      ch_q      <= '0;
      buf_q     <= '0;
      block_q   <= '0;
      valid_q   <= 1'b0;
      ch_out_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= overrun;
      // Consumed with nothing new to show; a transfer below overrides this
      if (valid_q && bus.out_ready) valid_q <= 1'b0;
      unique case (state_q)
        StFill: begin
          if (accept) begin
            if (complete && out_free) begin
              block_q   <= buf_wr;
              ch_out_q  <= ch_cur;
              valid_q   <= 1'b1;
              buf_q     <= '0;
              pos_q     <= '0;
              started_q <= 1'b0;
            end else if (complete) begin
              buf_q     <= buf_wr;
              ch_q      <= ch_cur;
              started_q <= 1'b1;
              state_q   <= StHold;
            end else begin
              buf_q     <= buf_wr;
              pos_q     <= t[5:0] + 6'd1;
              ch_q      <= ch_cur;
              started_q <= 1'b1;
            end
          end
        end
        StHold: begin
          if (out_free) begin
            block_q   <= buf_q;
            ch_out_q  <= ch_q;
            valid_q   <= 1'b1;
            buf_q     <= '0;
            pos_q     <= '0;
            started_q <= 1'b0;
            state_q   <= StFill;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StFill);
  assign bus.blockOut  = block_q;
  assign bus.valid_out = valid_q;
  assign bus.chOut     = ch_out_q;
  assign err           = err_q;

endmodule
